// File: rtl/column_eliminate.sv
// column_eliminate
//   Elimination stage of the fixed-point Gauss-Jordan inversion datapath. Holds the working
//   matrix as MAT_SIZE column vectors. Each pass it writes the normalized pivot column into
//   slot opCnt, subtracts the MAT_SIZE-1 substractor vectors from the remaining columns with
//   saturation, then advances opCnt and requests the next multiply pass. After the last
//   pass the columns are streamed out one per cycle.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin a new inversion (IDLE only)
//   loadVld/loadData    initial column beats, row r at [r*DATWIDTH +: DATWIDTH]
//   pivotVld/pivotColumn normalized pivot column for the current pass
//   subVld/sub          substractor vectors, [c][r] at [(c*MAT_SIZE+r)*DATWIDTH +: DATWIDTH]
//   opCnt               current pivot index
//   passReq             one-cycle request for the next multiply pass
//   colOutVld/colOutIdx/colOut  result column stream
//   busy, done          activity flag and end-of-drain pulse
//   satFlag, protoErr   sticky saturation / protocol-violation flags
module column_eliminate #(
    parameter int unsigned MAT_SIZE = 5,
    parameter int unsigned DATWIDTH = 64,
    parameter int unsigned CNTW     = $clog2(MAT_SIZE) + 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic                                     loadVld,
    input  logic [MAT_SIZE*DATWIDTH-1:0]             loadData,
    input  logic                                     pivotVld,
    input  logic [MAT_SIZE*DATWIDTH-1:0]             pivotColumn,
    input  logic                                     subVld,
    input  logic [(MAT_SIZE-1)*MAT_SIZE*DATWIDTH-1:0] sub,
    output logic [CNTW-1:0]                          opCnt,
    output logic                                     passReq,
    output logic                                     colOutVld,
    output logic [CNTW-1:0]                          colOutIdx,
    output logic [MAT_SIZE*DATWIDTH-1:0]             colOut,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     satFlag,
    output logic                                     protoErr
);

    localparam int unsigned COLW = MAT_SIZE * DATWIDTH;
    localparam int unsigned SUBW = (MAT_SIZE - 1) * COLW;
    localparam int unsigned IDXW = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;

    localparam logic [CNTW-1:0]     LAST_IDX = CNTW'(MAT_SIZE - 1);
    localparam logic [CNTW-1:0]     NUM_COLS = CNTW'(MAT_SIZE);
    localparam logic [CNTW-1:0]     CNT_ONE  = CNTW'(1);
    localparam logic [DATWIDTH-1:0] SAT_MAX  = {1'b0, {(DATWIDTH-1){1'b1}}};
    localparam logic [DATWIDTH-1:0] SAT_MIN  = {1'b1, {(DATWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StLoad, StWait, StUpdate, StDrain} state_e;

    // Returns {overflow, clamped a-b}; the difference is formed one bit wider so the
    // top two bits disagree exactly when the true result is out of range.
    function automatic logic [DATWIDTH:0] sat_sub(input logic [DATWIDTH-1:0] a,
                                                  input logic [DATWIDTH-1:0] b);
        logic [DATWIDTH:0] diff;
        diff = {a[DATWIDTH-1], a} - {b[DATWIDTH-1], b};
        if (diff[DATWIDTH] != diff[DATWIDTH-1]) begin
            return {1'b1, (diff[DATWIDTH] ? SAT_MIN : SAT_MAX)};
        end
        return {1'b0, diff[DATWIDTH-1:0]};
    endfunction

    // Substractor slot feeding column j: columns above the pivot shift down by one.
    function automatic int sub_slot(input int j, input logic [CNTW-1:0] piv);
        return (CNTW'(j) < piv) ? j : j - 1;
    endfunction

    state_e            state_q, state_d;
    logic [CNTW-1:0]   load_idx_q, load_idx_d;
    logic [CNTW-1:0]   op_cnt_q, op_cnt_d;
    logic [CNTW-1:0]   drain_idx_q, drain_idx_d;
    logic              piv_lat_q, piv_lat_d;
    logic              sub_lat_q, sub_lat_d;
    logic              pass_req_q, pass_req_d;
    logic              col_out_vld_q, col_out_vld_d;
    logic [CNTW-1:0]   col_out_idx_q, col_out_idx_d;
    logic [COLW-1:0]   col_out_q, col_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sat_q, sat_d;
    logic              err_q, err_d;

    logic [COLW-1:0]   col_q [MAT_SIZE];
    logic [COLW-1:0]   col_d [MAT_SIZE];
    logic [COLW-1:0]   piv_q;
    logic [SUBW-1:0]   sub_q;
    logic              piv_cap, sub_cap, load_we, upd_en, sat_any;
    logic [DATWIDTH:0] res;

    // ------------------------------------------------------------------ control FSM
    always_comb begin
        state_d       = state_q;
        load_idx_d    = load_idx_q;
        op_cnt_d      = op_cnt_q;
        drain_idx_d   = drain_idx_q;
        piv_lat_d     = piv_lat_q;
        sub_lat_d     = sub_lat_q;
        pass_req_d    = 1'b0;
        col_out_vld_d = 1'b0;
        col_out_idx_d = col_out_idx_q;
        col_out_d     = col_out_q;
        done_d        = 1'b0;
        sat_d         = sat_q;
        err_d         = err_q;
        piv_cap       = 1'b0;
        sub_cap       = 1'b0;
        load_we       = 1'b0;
        upd_en        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // busy_q is still high in the done cycle, so a start there is ignored.
                if (start && !busy_q) begin
                    state_d    = StLoad;
                    load_idx_d = '0;
                    op_cnt_d   = '0;
                    sat_d      = 1'b0;
                    err_d      = 1'b0;
                end
            end
            StLoad: begin
                if (pivotVld || subVld) begin
                    err_d = 1'b1;
                end
                if (loadVld) begin
                    load_we = 1'b1;
                    if (load_idx_q == LAST_IDX) begin
                        state_d    = StWait;
                        op_cnt_d   = '0;
                        pass_req_d = 1'b1;
                        piv_lat_d  = 1'b0;
                        sub_lat_d  = 1'b0;
                    end else begin
                        load_idx_d = load_idx_q + CNT_ONE;
                    end
                end
            end
            StWait: begin
                if (pivotVld) begin
                    if (piv_lat_q) begin
                        err_d = 1'b1;
                    end else begin
                        piv_lat_d = 1'b1;
                        piv_cap   = 1'b1;
                    end
                end
                if (subVld) begin
                    if (sub_lat_q) begin
                        err_d = 1'b1;
                    end else begin
                        sub_lat_d = 1'b1;
                        sub_cap   = 1'b1;
                    end
                end
                if (piv_lat_d && sub_lat_d) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                upd_en = 1'b1;
                if (sat_any) begin
                    sat_d = 1'b1;
                end
                if (op_cnt_q == LAST_IDX) begin
                    state_d     = StDrain;
                    drain_idx_d = '0;
                end else begin
                    state_d    = StWait;
                    op_cnt_d   = op_cnt_q + CNT_ONE;
                    pass_req_d = 1'b1;
                    piv_lat_d  = 1'b0;
                    sub_lat_d  = 1'b0;
                end
            end
            StDrain: begin
                // One extra cycle past the last column raises done.
                if (drain_idx_q == NUM_COLS) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    col_out_vld_d = 1'b1;
                    col_out_idx_d = drain_idx_q;
                    col_out_d     = col_q[drain_idx_q[IDXW-1:0]];
                    drain_idx_d   = drain_idx_q + CNT_ONE;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle) || done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            load_idx_q    <= '0;
            op_cnt_q      <= '0;
            drain_idx_q   <= '0;
            piv_lat_q     <= 1'b0;
            sub_lat_q     <= 1'b0;
            pass_req_q    <= 1'b0;
            col_out_vld_q <= 1'b0;
            col_out_idx_q <= '0;
            col_out_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sat_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_idx_q    <= load_idx_d;
            op_cnt_q      <= op_cnt_d;
            drain_idx_q   <= drain_idx_d;
            piv_lat_q     <= piv_lat_d;
            sub_lat_q     <= sub_lat_d;
            pass_req_q    <= pass_req_d;
            col_out_vld_q <= col_out_vld_d;
            col_out_idx_q <= col_out_idx_d;
            col_out_q     <= col_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sat_q         <= sat_d;
            err_q         <= err_d;
        end
    end

    // ------------------------------------------------------------------ matrix datapath
    // All targets read col_q, so every subtraction sees the pre-update matrix.
    always_comb begin
        sat_any = 1'b0;
        res     = '0;
        for (int j = 0; j < MAT_SIZE; j++) begin
            col_d[j] = col_q[j];
            if (load_we && (load_idx_q == CNTW'(j))) begin
                col_d[j] = loadData;
            end
            if (upd_en) begin
                if (op_cnt_q == CNTW'(j)) begin
                    col_d[j] = piv_q;
                end else begin
                    for (int r = 0; r < MAT_SIZE; r++) begin
                        res = sat_sub(col_q[j][r*DATWIDTH +: DATWIDTH],
                                      sub_q[(sub_slot(j, op_cnt_q)*MAT_SIZE + r)*DATWIDTH
                                            +: DATWIDTH]);
                        col_d[j][r*DATWIDTH +: DATWIDTH] = res[DATWIDTH-1:0];
                        sat_any = sat_any | res[DATWIDTH];
                    end
                end
            end
        end
    end

    // Matrix storage and operand latches carry no reset; their contents are don't-care
    // until loaded.
    always_ff @(posedge clk) begin
        col_q <= col_d;
        if (piv_cap) begin
            piv_q <= pivotColumn;
        end
        if (sub_cap) begin
            sub_q <= sub;
        end
    end

    assign opCnt     = op_cnt_q;
    assign passReq   = pass_req_q;
    assign colOutVld = col_out_vld_q;
    assign colOutIdx = col_out_idx_q;
    assign colOut    = col_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign satFlag   = sat_q;
    assign protoErr  = err_q;

endmodule

// File: tb/tb_column_eliminate.sv
// tb_column_eliminate
//   Directed and randomized bench for column_eliminate at MAT_SIZE=3, DATWIDTH=64. The
//   expected matrix is kept as plain signed integers and updated with wide arithmetic and
//   explicit range clamping.
module tb_column_eliminate;

    localparam int N    = 3;
    localparam int W    = 64;
    localparam int CW   = $clog2(N) + 1;
    localparam int COLW = N * W;
    localparam int SUBW = (N - 1) * N * W;

    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset, start, loadVld, pivotVld, subVld;
    logic [COLW-1:0] loadData, pivotColumn;
    logic [SUBW-1:0] sub;
    logic [CW-1:0]   opCnt, colOutIdx;
    logic            passReq, colOutVld, busy, done, satFlag, protoErr;
    logic [COLW-1:0] colOut;

    column_eliminate #(
        .MAT_SIZE (N),
        .DATWIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .loadVld     (loadVld),
        .loadData    (loadData),
        .pivotVld    (pivotVld),
        .pivotColumn (pivotColumn),
        .subVld      (subVld),
        .sub         (sub),
        .opCnt       (opCnt),
        .passReq     (passReq),
        .colOutVld   (colOutVld),
        .colOutIdx   (colOutIdx),
        .colOut      (colOut),
        .busy        (busy),
        .done        (done),
        .satFlag     (satFlag),
        .protoErr    (protoErr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mdl [N][N];  // mdl[column][row]
    bit          exp_sat, exp_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [COLW-1:0] obs, input logic [COLW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [COLW-1:0] pack_col(input int c);
        logic [COLW-1:0] v;
        for (int r = 0; r < N; r++) v[r*W +: W] = mdl[c][r];
        return v;
    endfunction

    function automatic logic [63:0] rnd64();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'(MAXV) - longint'($urandom_range(0, 3));
            1: v = longint'(MINV) + longint'($urandom_range(0, 3));
            2: v = longint'({$urandom, $urandom});
            default: v = longint'($urandom_range(0, 200)) - 100;
        endcase
        return v;
    endfunction

    function automatic logic [COLW-1:0] rnd_col();
        logic [COLW-1:0] v;
        for (int r = 0; r < N; r++) v[r*W +: W] = rnd64();
        return v;
    endfunction

    function automatic logic [SUBW-1:0] rnd_sub();
        logic [SUBW-1:0] v;
        for (int i = 0; i < (N - 1) * N; i++) v[i*W +: W] = rnd64();
        return v;
    endfunction

    // Gauss-Jordan elimination step on the reference matrix.
    task automatic apply_model(input int p, input logic [COLW-1:0] piv, input logic [SUBW-1:0] sb);
        logic signed [127:0] wa, wb, d, hi, lo;
        int t;
        hi = $signed(MAXV);
        lo = $signed(MINV);
        for (int c = 0; c < N - 1; c++) begin
            t = (c < p) ? c : c + 1;
            for (int r = 0; r < N; r++) begin
                wa = $signed(mdl[t][r]);
                wb = $signed(sb[(c*N + r)*W +: W]);
                d  = wa - wb;
                if (d > hi) begin
                    mdl[t][r] = MAXV;
                    exp_sat   = 1'b1;
                end else if (d < lo) begin
                    mdl[t][r] = MINV;
                    exp_sat   = 1'b1;
                end else begin
                    mdl[t][r] = d[63:0];
                end
            end
        end
        for (int r = 0; r < N; r++) mdl[p][r] = piv[r*W +: W];
    endtask

    task automatic load_all(input int gap, input bit bad);
        start = 1'b1;
        tick();
        start   = 1'b0;
        exp_sat = 1'b0;
        exp_err = bad;
        chk("start_busy", busy, 1'b1);
        chk("start_sat_clr", satFlag, 1'b0);
        chk("start_err_clr", protoErr, 1'b0);
        for (int c = 0; c < N; c++) begin
            repeat (gap) tick();
            loadVld  = 1'b1;
            loadData = pack_col(c);
            if (bad && c == 1) pivotVld = 1'b1;
            tick();
            loadVld  = 1'b0;
            pivotVld = 1'b0;
            loadData = '1;
        end
        chk("load_passreq", passReq, 1'b1);
        chk("load_opcnt", opCnt, '0);
        chk("load_err", protoErr, exp_err);
        tick();
        chk("load_passreq_pulse", passReq, 1'b0);
    endtask

    // mode 0: both valids together; 1: sub first; 2: pivot first; 3: duplicate sub.
    task automatic do_pass(input int p, input int mode, input int gap, input logic [COLW-1:0] piv,
                           input logic [SUBW-1:0] sb, input logic [SUBW-1:0] sb2);
        pivotColumn = piv;
        sub         = sb;
        case (mode)
            0: begin
                pivotVld = 1'b1;
                subVld   = 1'b1;
                tick();
                pivotVld = 1'b0;
                subVld   = 1'b0;
            end
            1: begin
                subVld = 1'b1;
                tick();
                subVld = 1'b0;
                sub    = ~sb;
                repeat (gap) begin
                    start = 1'b1;  // ignored while busy
                    tick();
                    start = 1'b0;
                end
                pivotVld = 1'b1;
                tick();
                pivotVld = 1'b0;
            end
            2: begin
                pivotVld = 1'b1;
                tick();
                pivotVld    = 1'b0;
                pivotColumn = ~piv;
                repeat (gap) tick();
                subVld = 1'b1;
                tick();
                subVld = 1'b0;
            end
            default: begin
                subVld = 1'b1;
                tick();
                sub = sb2;
                tick();
                subVld   = 1'b0;
                sub      = ~sb;
                exp_err  = 1'b1;
                pivotVld = 1'b1;
                tick();
                pivotVld = 1'b0;
            end
        endcase
        chk("update_passreq_low", passReq, 1'b0);
        apply_model(p, piv, sb);
        tick();
        chk("pass_passreq", passReq, (p < N - 1) ? 1'b1 : 1'b0);
        chk("pass_opcnt", opCnt, (p < N - 1) ? p + 1 : p);
        chk("pass_sat", satFlag, exp_sat);
        chk("pass_err", protoErr, exp_err);
        chk("pass_busy", busy, 1'b1);
    endtask

    task automatic drain_check();
        chk("drain_pre_vld", colOutVld, 1'b0);
        for (int k = 0; k < N; k++) begin
            tick();
            chk("drain_vld", colOutVld, 1'b1);
            chk("drain_idx", colOutIdx, k);
            chk("drain_col", colOut, pack_col(k));
            chk("drain_done_low", done, 1'b0);
            chk("drain_sat", satFlag, exp_sat);
            chk("drain_err", protoErr, exp_err);
        end
        tick();
        chk("done_pulse", done, 1'b1);
        chk("done_vld_low", colOutVld, 1'b0);
        chk("done_busy", busy, 1'b1);
        tick();
        chk("done_single", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_sat", satFlag, exp_sat);
        chk("idle_err", protoErr, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_opcnt"}, opCnt, '0);
        chk({tag, "_passreq"}, passReq, 1'b0);
        chk({tag, "_vld"}, colOutVld, 1'b0);
        chk({tag, "_idx"}, colOutIdx, '0);
        chk({tag, "_col"}, colOut, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_sat"}, satFlag, 1'b0);
        chk({tag, "_err"}, protoErr, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [COLW-1:0] piv;
        logic [SUBW-1:0] sb, sb2;

        reset       = 1'b1;
        start       = 1'b0;
        loadVld     = 1'b0;
        pivotVld    = 1'b0;
        subVld      = 1'b0;
        loadData    = '0;
        pivotColumn = '0;
        sub         = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle_after_reset", busy, 1'b0);

        // Directed run: worked example with saturation and a duplicate substractor.
        for (int c = 0; c < N; c++)
            for (int r = 0; r < N; r++) mdl[c][r] = 64'(c * N + r + 1);
        load_all(0, 1'b0);

        for (int r = 0; r < N; r++) begin
            piv[r*W +: W]       = 64'd10;
            sb[(0*N + r)*W +: W] = 64'd1;
            sb[(1*N + r)*W +: W] = 64'd2;
        end
        do_pass(0, 0, 0, piv, sb, '0);

        piv = {64'd30, 64'd20, MAXV};
        for (int r = 0; r < N; r++) begin
            sb[(0*N + r)*W +: W] = 64'(r + 1);
            sb[(1*N + r)*W +: W] = 64'(r + 4);
        end
        do_pass(1, 1, 2, piv, sb, '0);

        piv = {64'd300, 64'd200, 64'd100};
        for (int r = 0; r < N; r++) begin
            sb[(0*N + r)*W +: W]  = 64'd5;
            sb[(1*N + r)*W +: W]  = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
            sb2[(0*N + r)*W +: W] = 64'd7;
            sb2[(1*N + r)*W +: W] = 64'd7;
        end
        do_pass(2, 3, 0, piv, sb, sb2);
        drain_check();

        // Reset in the middle of pass 1.
        for (int c = 0; c < N; c++)
            for (int r = 0; r < N; r++) mdl[c][r] = rnd64();
        load_all(1, 1'b1);
        do_pass(0, 0, 0, rnd_col(), rnd_sub(), '0);
        subVld = 1'b1;
        sub    = rnd_sub();
        tick();
        subVld = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midpass_reset");
        pivotVld = 1'b1;
        subVld   = 1'b1;
        loadVld  = 1'b1;
        tick();
        pivotVld = 1'b0;
        subVld   = 1'b0;
        loadVld  = 1'b0;
        chk("idle_ignores_inputs_busy", busy, 1'b0);
        chk("idle_ignores_inputs_err", protoErr, 1'b0);

        // Randomized complete inversions.
        for (int run = 0; run < 6; run++) begin
            for (int c = 0; c < N; c++)
                for (int r = 0; r < N; r++) mdl[c][r] = rnd64();
            load_all($urandom_range(0, 2), 1'b0);
            for (int p = 0; p < N; p++) begin
                do_pass(p, $urandom_range(0, 3), $urandom_range(0, 3), rnd_col(), rnd_sub(),
                        rnd_sub());
            end
            drain_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
